// File: rtl/mult_seq_core.sv
// -----------------------------------------------------------------------------
// mult_seq_core
//   Sequential 16x16 signed multiplier with argument parity checking.
//   An operation is captured from IDLE when req is high, the captured
//   argument parity is checked, and the product is formed by 16 radix-2
//   Booth shift-add steps. All outputs are registered.
//
// Ports
//   clk              in   1  sole clock, rising edge
//   rst_n            in   1  synchronous active-low reset
//   req              in   1  request, arguments valid while high
//   arg_a            in  16  signed multiplicand
//   arg_a_parity     in   1  even parity of arg_a (XOR of its bits)
//   arg_b            in  16  signed multiplier
//   arg_b_parity     in   1  even parity of arg_b
//   ack              out  1  one-cycle pulse after arguments are captured
//   result           out 32  signed product
//   result_parity    out  1  XOR of result bits
//   result_rdy       out  1  one-cycle pulse, result and flags valid
//   arg_parity_error out  1  argument parity mismatch for this result
// -----------------------------------------------------------------------------
module mult_seq_core #(
  parameter int CHECK_PARITY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [15:0] arg_a,
  input  logic        arg_a_parity,
  input  logic [15:0] arg_b,
  input  logic        arg_b_parity,
  output logic        ack,
  output logic [31:0] result,
  output logic        result_parity,
  output logic        result_rdy,
  output logic        arg_parity_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, next_state;

  // Booth accumulator: acc_hi holds the running partial product (one guard
  // bit so that subtracting -32768 cannot overflow), acc_lo starts as the
  // multiplier and fills with product bits, acc_q is the Booth look-behind bit.
  logic [15:0] mcand;
  logic [16:0] acc_hi;
  logic [15:0] acc_lo;
  logic        acc_q;
  logic        par_a;
  logic        par_b;
  logic        par_err;
  logic [3:0]  step_cnt;

  logic [16:0] mcand_ext;
  logic [16:0] sum_hi;
  logic [16:0] step_hi;
  logic [15:0] step_lo;
  logic        step_q;
  logic [31:0] final_prod;
  logic        par_err_now;

  assign mcand_ext = {mcand[15], mcand};

  // One Booth step: add/subtract the multiplicand according to the current
  // bit pair, then arithmetic shift the whole accumulator right by one.
  always_comb begin
    sum_hi = acc_hi;
    case ({acc_lo[0], acc_q})
      2'b01:   sum_hi = acc_hi + mcand_ext;
      2'b10:   sum_hi = acc_hi - mcand_ext;
      default: sum_hi = acc_hi;
    endcase
    step_hi = {sum_hi[16], sum_hi[16:1]};
    step_lo = {sum_hi[0], acc_lo[15:1]};
    step_q  = acc_lo[0];
  end

  // The 16th step is folded into the DONE cycle, so the final product is the
  // combinational result of that last step.
  assign final_prod = {step_hi[15:0], step_lo};

  // During CHECK, acc_lo still holds the captured multiplier.
  assign par_err_now = (CHECK_PARITY != 0) &&
                       (((^mcand) != par_a) || ((^acc_lo) != par_b));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // MUL runs 15 steps (counter 0..14); the last step happens on the DONE edge.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = CHECK;
      CHECK:   next_state = par_err_now ? DONE : MUL;
      MUL:     if (step_cnt == 4'd14) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack              <= 1'b0;
      result           <= 32'd0;
      result_parity    <= 1'b0;
      result_rdy       <= 1'b0;
      arg_parity_error <= 1'b0;
      mcand            <= 16'd0;
      acc_hi           <= 17'd0;
      acc_lo           <= 16'd0;
      acc_q            <= 1'b0;
      par_a            <= 1'b0;
      par_b            <= 1'b0;
      par_err          <= 1'b0;
      step_cnt         <= 4'd0;
    end else begin
      ack        <= (state == IDLE) && req;
      result_rdy <= (state == DONE);
      case (state)
        IDLE: begin
          if (req) begin
            mcand    <= arg_a;
            acc_hi   <= 17'd0;
            acc_lo   <= arg_b;
            acc_q    <= 1'b0;
            par_a    <= arg_a_parity;
            par_b    <= arg_b_parity;
            step_cnt <= 4'd0;
          end
        end
        CHECK: begin
          par_err  <= par_err_now;
          step_cnt <= 4'd0;
        end
        MUL: begin
          acc_hi   <= step_hi;
          acc_lo   <= step_lo;
          acc_q    <= step_q;
          step_cnt <= step_cnt + 4'd1;
        end
        DONE: begin
          if (par_err) begin
            result           <= 32'd0;
            result_parity    <= 1'b0;
            arg_parity_error <= 1'b1;
          end else begin
            result           <= final_prod;
            result_parity    <= ^final_prod;
            arg_parity_error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_core.sv
module tb_mult_seq_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [15:0] arg_a;
  logic        arg_a_parity;
  logic [15:0] arg_b;
  logic        arg_b_parity;

  logic        ack;
  logic [31:0] result;
  logic        result_parity;
  logic        result_rdy;
  logic        arg_parity_error;

  logic        np_ack;
  logic [31:0] np_result;
  logic        np_result_parity;
  logic        np_result_rdy;
  logic        np_arg_parity_error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bad_a;
    logic        bad_b;
    logic [31:0] exp_res;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          cap;
    int          lat;
  } exp_t;

  exp_t sb[$];

  mult_seq_core #(.CHECK_PARITY(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .arg_a(arg_a), .arg_a_parity(arg_a_parity),
    .arg_b(arg_b), .arg_b_parity(arg_b_parity),
    .ack(ack), .result(result), .result_parity(result_parity),
    .result_rdy(result_rdy), .arg_parity_error(arg_parity_error)
  );

  mult_seq_core #(.CHECK_PARITY(0)) dut_np (
    .clk(clk), .rst_n(rst_n), .req(req),
    .arg_a(arg_a), .arg_a_parity(arg_a_parity),
    .arg_b(arg_b), .arg_b_parity(arg_b_parity),
    .ack(np_ack), .result(np_result), .result_parity(np_result_parity),
    .result_rdy(np_result_rdy), .arg_parity_error(np_arg_parity_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive one operation and hold req until the ack pulse is seen, then push
  // the expected outcome and scramble the argument inputs.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic bad_a, input logic bad_b,
                               input logic [31:0] exp_res, input logic exp_err,
                               output int cap);
    int n;
    bit got;
    arg_a        = a;
    arg_b        = b;
    arg_a_parity = (^a) ^ bad_a;
    arg_b_parity = (^b) ^ bad_b;
    req          = 1'b1;
    n   = 0;
    got = 0;
    cap = -1;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ack) got = 1;
    end
    if (!got) begin
      checkOutput("ack_timeout", 32'd0, 32'd1);
    end else begin
      checkOutput("ack_latency", 32'(n), 32'd1);
      cap = cyc;
      sb.push_back('{exp_res, exp_err, cyc, exp_err ? 2 : 17});
    end
    req          = 1'b0;
    arg_a        = 16'($urandom);
    arg_b        = 16'($urandom);
    arg_a_parity = 1'($urandom);
    arg_b_parity = 1'($urandom);
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (n % 5 == 0) arg_b = 16'($urandom);
    end
    checkOutput("drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ack"}, 32'(ack), 32'd0);
    checkOutput({tag, "_rdy"}, 32'(result_rdy), 32'd0);
    checkOutput({tag, "_result"}, result, 32'd0);
    checkOutput({tag, "_parity"}, 32'(result_parity), 32'd0);
    checkOutput({tag, "_err"}, 32'(arg_parity_error), 32'd0);
  endtask

  // Scoreboard monitor: pops expected results on result_rdy and checks
  // pulse widths and that outputs stay put between result_rdy pulses.
  logic        ack_prev = 1'b0;
  logic        rdy_prev = 1'b0;
  logic [31:0] held_res = 32'd0;
  logic        held_par = 1'b0;
  logic        held_err = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (ack) checkOutput("ack_width", 32'(ack_prev), 32'd0);
    ack_prev = ack;
    if (!rst_n) begin
      held_res = 32'd0;
      held_par = 1'b0;
      held_err = 1'b0;
    end else if (result_rdy) begin
      checkOutput("rdy_width", 32'(rdy_prev), 32'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_rdy", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("result_parity", 32'(result_parity), 32'(^e.res));
        checkOutput("parity_error", 32'(arg_parity_error), 32'(e.err));
        checkOutput("rdy_latency", 32'(cyc - e.cap), 32'(e.lat));
      end
      held_res = result;
      held_par = result_parity;
      held_err = arg_parity_error;
    end else if (!rdy_prev) begin
      checkOutput("hold_result", result, held_res);
      checkOutput("hold_flags", {30'd0, result_parity, arg_parity_error},
                  {30'd0, held_par, held_err});
    end
    rdy_prev = result_rdy;
  end

  vec_t vecs[10];

  initial begin
    int cap;
    int cap1;
    int n;
    bit got;

    vecs[0] = '{16'h0003, 16'hFFFB, 1'b0, 1'b0, 32'hFFFF_FFF1, 1'b0};
    vecs[1] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 32'h4000_0000, 1'b0};
    vecs[2] = '{16'h8000, 16'h7FFF, 1'b0, 1'b0, 32'hC000_8000, 1'b0};
    vecs[3] = '{16'h0003, 16'hFFFB, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
    vecs[4] = '{16'h0007, 16'h0006, 1'b0, 1'b0, 32'h0000_002A, 1'b0};
    vecs[5] = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 32'h3FFF_0001, 1'b0};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'h0000_0001, 1'b0};
    vecs[8] = '{16'h0005, 16'h0009, 1'b0, 1'b1, 32'h0000_0000, 1'b1};
    vecs[9] = '{16'h0100, 16'hFF00, 1'b0, 1'b0, 32'hFFFF_0000, 1'b0};

    // Reset with req held high: outputs must stay at reset values.
    rst_n = 1'b0;
    req   = 1'b1;
    arg_a = 16'h0007; arg_b = 16'h0006;
    arg_a_parity = 1'b1; arg_b_parity = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkResetOutputs("reset");
      checkOutput("reset_np_ack", 32'(np_ack), 32'd0);
    end
    req   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bad_a, vecs[i].bad_b,
                    vecs[i].exp_res, vecs[i].exp_err, cap);
      waitDone(40);
    end

    $display("[TB] reset during MUL");
    applyStimulus(16'h0007, 16'h0006, 1'b0, 1'b0, 32'h2A, 1'b0, cap);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    checkResetOutputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    applyStimulus(16'h0003, 16'hFFFB, 1'b0, 1'b0, 32'hFFFF_FFF1, 1'b0, cap);
    waitDone(40);

    $display("[TB] back-to-back with req held");
    arg_a = 16'h0007; arg_b = 16'h0006;
    arg_a_parity = 1'b1; arg_b_parity = 1'b0;
    req = 1'b1;
    n = 0; got = 0; cap1 = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ack) got = 1;
    end
    checkOutput("b2b_ack1", 32'(got), 32'd1);
    cap1 = cyc;
    sb.push_back('{32'd42, 1'b0, cyc, 17});
    arg_a = 16'h0000; arg_b = 16'hFFFF;
    arg_a_parity = 1'b0; arg_b_parity = 1'b0;
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ack) got = 1;
    end
    checkOutput("b2b_ack2", 32'(got), 32'd1);
    checkOutput("b2b_capture", 32'(cyc - cap1), 32'd18);
    sb.push_back('{32'd0, 1'b0, cyc, 17});
    req = 1'b0;
    waitDone(40);

    $display("[TB] parity checking disabled");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(16'h0003, 16'hFFFB, 1'b1, 1'b0, 32'd0, 1'b1, cap);
    n = 0;
    while (!np_result_rdy && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("np_rdy_seen", 32'(np_result_rdy), 32'd1);
    checkOutput("np_latency", 32'(cyc - cap), 32'd17);
    checkOutput("np_result", np_result, 32'hFFFF_FFF1);
    checkOutput("np_parity", 32'(np_result_parity), 32'd1);
    checkOutput("np_err", 32'(np_arg_parity_error), 32'd0);
    waitDone(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq_core.md
MULT_SEQ_CORE -- requirements
Module: mult_seq_core

Interface
REQ-001 SHALL have parameter: CHECK_PARITY, default 1, 1 = argument parity checked, 0 = parity error never flagged.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  synchronous active-low reset, sampled on rising clk edge.
REQ-004 SHALL have port: req  input  1  initiator request, args valid while high.
REQ-005 SHALL have port: arg_a  input  16  signed multiplicand, two's complement.
REQ-006 SHALL have port: arg_a_parity  input  1  even parity bit for arg_a (equals XOR of arg_a bits).
REQ-007 SHALL have port: arg_b  input  16  signed multiplier, two's complement.
REQ-008 SHALL have port: arg_b_parity  input  1  even parity bit for arg_b.
REQ-009 SHALL have port: ack  output  1  one-cycle pulse, args captured.
REQ-010 SHALL have port: result  output  32  signed product, registered.
REQ-011 SHALL have port: result_parity  output  1  XOR of result bits, registered.
REQ-012 SHALL have port: result_rdy  output  1  one-cycle pulse, result/flags valid.
REQ-013 SHALL have port: arg_parity_error  output  1  registered, set when either arg parity mismatches.

Function
REQ-014 SHALL implement FSM states IDLE, CHECK, MUL, DONE; all outputs registered.
REQ-015 SHALL, in IDLE with req=1 at edge E0, capture arg_a, arg_b, both parity bits and enter CHECK.
REQ-016 SHALL drive ack=1 from E0 to E1 only; ack never high outside that cycle.
REQ-017 SHALL ignore req in every state except IDLE; args changing after E0 have no effect.
REQ-018 SHALL, in CHECK at E1, compare captured parity bits against XOR of captured args (when CHECK_PARITY=1).
REQ-019 SHALL, on mismatch at E1, enter DONE with result=0, result_parity=0, arg_parity_error=1; result_rdy high E2..E3.
REQ-020 SHALL, on match at E1, enter MUL and perform 16 iterative shift-add steps on edges E2..E17.
REQ-021 SHALL produce the exact 32-bit two's-complement product, including -32768 x -32768 = 32'h4000_0000 and -32768 x 32767.
REQ-022 SHALL, on a good operation, register result, result_parity=^result and arg_parity_error=0 at E17, with result_rdy high E17..E18.
REQ-023 SHALL, in DONE, return to IDLE on the next edge; earliest new capture is the edge after result_rdy drops (E18, or E3 on error).
REQ-024 SHALL hold result, result_parity and arg_parity_error stable from result_rdy until the next result_rdy.
REQ-025 SHALL, when req is held high continuously, capture a new operation at the first IDLE edge (back-to-back operation).
REQ-026 SHALL, with CHECK_PARITY=0, always take the MUL path regardless of parity inputs.

Reset
REQ-027 SHALL, on rst_n=0 at a rising edge, enter IDLE and set ack=0, result_rdy=0, result=0, result_parity=0, arg_parity_error=0, clear the internal accumulator and counter.
REQ-028 SHALL abort any operation in progress on reset with no result_rdy pulse for it; the first capture is at the first edge with rst_n=1 and req=1.
REQ-029 SHALL keep all outputs at reset values for the entire time rst_n=0, regardless of req.

Verification
REQ-030 SHALL cover: arg_a=3 (par 0), arg_b=-5 (par 1) -> ack pulse 1 cycle after capture, result=32'hFFFF_FFF1, result_parity=1, error=0, result_rdy 17 cycles after capture.
REQ-031 SHALL cover: arg_a=arg_b=16'h8000 (par 1 each) -> result=32'h4000_0000, result_parity=1.
REQ-032 SHALL cover: arg_a=3 with arg_a_parity=1 -> arg_parity_error=1, result=0, result_parity=0, result_rdy 2 cycles after capture.
REQ-033 SHALL cover: rst_n=0 asserted in MUL step 8 -> no result_rdy, all outputs 0, next valid request completes correctly.
REQ-034 SHALL cover: req held high across two operations (7x6 then 0x-1) -> two ack pulses, results 42 then 0, second capture exactly at the edge after first result_rdy drops.
REQ-035 SHALL cover: arg_b changed while in MUL -> result unaffected (uses captured value).
